// File: rtl/fifo_rr_drain.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain
//
// Round-robin read scheduler. It drains NUM_Q first-word-fall-through FIFOs
// into one registered valid/ready output stream. One queue is granted at a
// time. A grant lasts for up to BURST_LEN pops, or ends early when that queue
// runs empty. The pointer then rotates to the queue after the granted one.
//
// Optional feature (compile-time macro FIFO_RR_DRAIN_PRIO0_EN):
//   Queue 0 gets strict priority. Whenever queue 0 is non-empty in IDLE it is
//   granted, its burst ignores BURST_LEN and runs until queue 0 is empty, and
//   such a burst leaves the round-robin pointer where it was.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   rst_n      in   asynchronous active-low reset
//   q_empty    in   [NUM_Q]            per-queue empty; 0 = head word valid
//   q_rdata    in   [NUM_Q*DATA_WIDTH] packed head words, queue i at
//                                      [i*DATA_WIDTH +: DATA_WIDTH]
//   q_ren      out  [NUM_Q]            one-hot pop strobe (combinational)
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts when out_valid && out_ready
//   out_data   out  [DATA_WIDTH]       registered word
//   out_qid    out  [QID_WIDTH]        source queue of out_data
//   busy       out  high while a grant (BURST state) is active
// -----------------------------------------------------------------------------
module fifo_rr_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_Q      = 4,
  parameter int BURST_LEN  = 4,
  parameter int QID_WIDTH  = $clog2(NUM_Q),
  parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_Q-1:0]            q_empty,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_rdata,
  output logic [NUM_Q-1:0]            q_ren,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_WIDTH-1:0]        out_qid,
  output logic                        busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Scan arithmetic carries one extra bit so rr_ptr + offset can exceed
  // NUM_Q-1 before the wrap subtraction.
  localparam int SCAN_WIDTH = QID_WIDTH + 1;

  state_t                 state_q;
  state_t                 state_d;
  logic [QID_WIDTH-1:0]   rr_ptr;
  logic [QID_WIDTH-1:0]   rr_ptr_d;
  logic [QID_WIDTH-1:0]   grant;
  logic [QID_WIDTH-1:0]   grant_d;
  logic [CNT_WIDTH-1:0]   burst_cnt;
  logic [CNT_WIDTH-1:0]   burst_cnt_d;
  logic                   out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_d;
  logic [QID_WIDTH-1:0]   out_qid_d;

  // Head word of every queue, unpacked so the granted one is a plain index.
  logic [DATA_WIDTH-1:0]  head_word [NUM_Q];

  logic                   any_req;
  logic                   rr_found;
  logic [QID_WIDTH-1:0]   rr_pick;
  logic [QID_WIDTH-1:0]   pick;
  logic [SCAN_WIDTH-1:0]  scan_sum;
  logic [QID_WIDTH-1:0]   scan_idx;

  logic                   load_en;
  logic                   pop;
  logic                   prio_burst;
  logic [QID_WIDTH-1:0]   grant_inc;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  // ---------------------------------------------------------------------------
  // Head-word unpacking
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      head_word[i] = q_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first non-empty queue at or after rr_ptr, with wrap.
  // The explicit subtract (rather than masking) keeps a non-power-of-two
  // NUM_Q wrapping at NUM_Q instead of at 2**QID_WIDTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      scan_sum = {1'b0, rr_ptr} + SCAN_WIDTH'(i);
      if (scan_sum >= SCAN_WIDTH'(NUM_Q)) begin
        scan_sum = scan_sum - SCAN_WIDTH'(NUM_Q);
      end
      scan_idx = scan_sum[QID_WIDTH-1:0];
      if (!rr_found && !q_empty[scan_idx]) begin
        rr_found = 1'b1;
        rr_pick  = scan_idx;
      end
    end
  end

  assign any_req = ~&q_empty;

`ifdef FIFO_RR_DRAIN_PRIO0_EN
  // Queue 0 overrides the rotation whenever it holds data, and a burst on it
  // is open-ended and does not move the pointer.
  assign pick       = q_empty[0] ? rr_pick : '0;
  assign prio_burst = (grant == '0);
`else
  assign pick       = rr_pick;
  assign prio_burst = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Burst bookkeeping helpers
  // ---------------------------------------------------------------------------
  // The output register can take a new word when it is empty or is being
  // consumed in this same cycle; this gives one word per cycle at full rate.
  assign load_en   = !out_valid || out_ready;
  assign pop       = (state_q == ST_BURST) && load_en && !q_empty[grant];
  assign grant_inc = (grant == QID_WIDTH'(NUM_Q - 1)) ? '0 : grant + QID_WIDTH'(1);
  assign cnt_inc   = burst_cnt + CNT_WIDTH'(1);
  assign busy      = (state_q == ST_BURST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    grant_d     = grant;
    burst_cnt_d = burst_cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_qid_d   = out_qid;
    q_ren       = '0;

    // Consumer took the held word and nothing replaces it: register empties.
    // A pop in the same cycle overrides this below.
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (any_req) begin
          grant_d = pick;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        if (pop) begin
          q_ren[grant] = 1'b1;
          out_valid_d  = 1'b1;
          out_data_d   = head_word[grant];
          out_qid_d    = grant;
          if (!prio_burst) begin
            burst_cnt_d = cnt_inc;
            if (cnt_inc == CNT_WIDTH'(BURST_LEN)) begin
              state_d  = ST_IDLE;
              rr_ptr_d = grant_inc;
            end
          end
        end else if (q_empty[grant]) begin
          // Granted queue ran dry: end the grant even if the output is
          // stalled, so other queues are not held off by a stuck consumer.
          state_d = ST_IDLE;
          if (!prio_burst) begin
            rr_ptr_d = grant_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      // NOTE: the output data/qid registers are reset as well, so a consumer
      // that ignores out_valid still sees zeros after reset rather than X.
      out_data  <= '0;
      out_qid   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values computed above regardless of evaluation order.
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant     <= grant_d;
      burst_cnt <= burst_cnt_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_qid   <= out_qid_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_rr_drain
//
// Bench for fifo_rr_drain. The per-source FIFOs live here as queues. Each
// scenario loads words into them, and a transaction-level model then predicts
// the order in which the words leave the scheduler. That order is pushed into
// a scoreboard queue. An independent monitor pops it on every accepted
// output beat. The monitor also checks pop-strobe legality and output hold
// during stalls on every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_rr_drain;

  localparam int DW = 8;
  localparam int NQ = 4;
  localparam int BL = 4;
  localparam int QW = $clog2(NQ);

`ifdef FIFO_RR_DRAIN_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NQ-1:0]     q_empty;
  logic [NQ*DW-1:0]  q_rdata;
  logic [NQ-1:0]     q_ren;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [QW-1:0]     out_qid;
  logic              busy;

  fifo_rr_drain #(
    .DATA_WIDTH(DW),
    .NUM_Q     (NQ),
    .BURST_LEN (BL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .q_empty  (q_empty),
    .q_rdata  (q_rdata),
    .q_ren    (q_ren),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_qid  (out_qid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [QW-1:0] qid;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] src_q [NQ][$];   // source FIFO contents, head at index 0
  beat_t         exp_q [$];       // scoreboard: expected output beats in order
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_acc    = 0;    // beats accepted by the consumer
  int            pop_cnt [NQ];    // pops observed per queue
  int            m_ptr    = 0;    // model round-robin pointer

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present each FIFO's empty flag and head word to the DUT.
  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i] = (src_q[i].size() == 0);
      q_rdata[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  // One clock cycle. Called 1 ns after a rising edge. Samples the pop strobe
  // away from the edge, then retires the popped words just after the edge.
  task automatic tick(output logic [NQ-1:0] ren);
    refresh();
    @(negedge clk);
    ren = q_ren;
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (ren[i]) begin
        pop_cnt[i]++;
        if (src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
    end
    refresh();
  endtask

  // Transaction-level model. Given the words now sitting in the FIFOs, it
  // lists the order they come out. A grant goes to the first non-empty queue
  // from the pointer (or to queue 0 under priority). It takes up to BL words
  // (all of them for a priority burst). The pointer then moves past the
  // granted queue.
  task automatic plan();
    int    avail [NQ];
    int    base  [NQ];
    int    g;
    int    n;
    bit    done;
    beat_t b;
    for (int i = 0; i < NQ; i++) begin
      avail[i] = src_q[i].size();
      base[i]  = 0;
    end
    done = 1'b0;
    while (!done) begin
      g = -1;
      if (PRIO0 && avail[0] > 0) g = 0;
      for (int k = 0; k < NQ; k++) begin
        if (g < 0 && avail[(m_ptr + k) % NQ] > 0) g = (m_ptr + k) % NQ;
      end
      if (g < 0) begin
        done = 1'b1;
      end else begin
        n = 0;
        while (avail[g] > 0 && (n < BL || (PRIO0 && g == 0))) begin
          b.qid  = QW'(g);
          b.data = src_q[g][base[g]];
          exp_q.push_back(b);
          base[g]++;
          avail[g]--;
          n++;
        end
        if (!(PRIO0 && g == 0)) m_ptr = (g + 1) % NQ;
      end
    end
  endtask

  // Run until every predicted beat is consumed and the DUT is idle.
  task automatic run_drain(input string name, input bit rnd_ready, input int budget);
    logic [NQ-1:0] r;
    int            c;
    int            left;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(r);
      c++;
    end
    out_ready = 1'b1;
    if (c >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d beats still outstanding after %0d cycles", name, exp_q.size(), c);
      exp_q.delete();
    end else begin
      left = 0;
      for (int i = 0; i < NQ; i++) left += src_q[i].size();
      check({name, "_fifos_drained"}, 32'(left), 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard compare plus per-cycle protocol checks
  // ---------------------------------------------------------------------------
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("ren_onehot0", 32'($onehot0(q_ren)), 1);
      check("ren_on_empty", 32'(q_ren & q_empty), 0);
      if (!busy) check("ren_in_idle", 32'(q_ren), 0);
      if (out_valid && !out_ready) check("ren_in_stall", 32'(q_ren), 0);
      if (prev_stall) begin
        check("stall_hold_valid", 32'(out_valid), 1);
        check("stall_hold_word", 32'({out_qid, out_data}), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got qid %0d data 0x%0h, expected none", out_qid, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_qid", 32'(out_qid), 32'(mon_e.qid));
          check("beat_data", 32'(out_data), 32'(mon_e.data));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_qid, out_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [NQ-1:0] r;
    logic [6:0]    rdy_pat;
    int            c;
    int            acc0;
    int            p0;

    for (int i = 0; i < NQ; i++) pop_cnt[i] = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    refresh();

    // ---- Reset values ------------------------------------------------------
    #22;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_qid", 32'(out_qid), 0);
    check("rst_q_ren", 32'(q_ren), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 0);
    check("rst_grant", 32'(dut.grant), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- All queues empty for 20 cycles ------------------------------------
    for (int k = 0; k < 20; k++) begin
      tick(r);
      check("idle_q_ren", 32'(r), 0);
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_busy", 32'(busy), 0);
    end

    // ---- Four queues x 6 words, full-rate consumer -------------------------
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 6; k++) src_q[q].push_back(8'(q * 16 + k));
    plan();
    tick(r);
    check("lat_no_pop_in_idle", 32'(r), 0);
    check("lat_busy_after_grant", 32'(busy), 1);
    check("lat_valid_not_yet", 32'(out_valid), 0);
    tick(r);
    check("lat_first_pop_q0", 32'(r), 32'h1);
    check("lat_valid_at_2", 32'(out_valid), 1);
    check("lat_first_qid", 32'(out_qid), 0);
    check("lat_first_data", 32'(out_data), 32'h00);
    run_drain("four_q", 1'b0, 200);

    // ---- Only queue 2 with 2 words -----------------------------------------
    p0 = pop_cnt[2];
    src_q[2].push_back(8'hA0);
    src_q[2].push_back(8'hA1);
    plan();
    run_drain("q2_only", 1'b0, 50);
    check("q2_only_pops", 32'(pop_cnt[2] - p0), 2);
    check("q2_only_rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    check("q2_only_rr_ptr_is_3", 32'(dut.rr_ptr), 3);
    check("q2_only_idle", 32'(busy), 0);

    // ---- Queue 1 with 4 words under a stall pattern ------------------------
    acc0 = n_acc;
    for (int k = 0; k < 4; k++) src_q[1].push_back(8'hB0 + 8'(k));
    plan();
    rdy_pat = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
    for (int k = 0; k < 7; k++) begin
      out_ready = rdy_pat[k];
      tick(r);
    end
    run_drain("stall", 1'b0, 50);
    check("stall_accepted_beats", 32'(n_acc - acc0), 4);

    // ---- Reset mid-burst on queue 3 ----------------------------------------
    p0 = pop_cnt[3];
    for (int k = 0; k < 6; k++) src_q[3].push_back(8'hC0 + 8'(k));
    exp_q.push_back('{qid: QW'(3), data: 8'hC0});   // C1 will sit in the output register and be lost
    c = 0;
    while (pop_cnt[3] - p0 < 2 && c < 20) begin
      tick(r);
      c++;
    end
    check("rst_mid_two_pops", 32'(pop_cnt[3] - p0), 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_rr_ptr", 32'(dut.rr_ptr), 0);
    check("rst_mid_grant", 32'(dut.grant), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_q_ren", 32'(q_ren), 0);
    check("rst_mid_first_delivered", 32'(exp_q.size()), 0);
    m_ptr = 0;
    src_q[1].push_back(8'hD0);   // arbitration from 0 must reach queue 1 before queue 3
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    plan();
    run_drain("after_rst", 1'b0, 60);

`ifdef FIFO_RR_DRAIN_PRIO0_EN
    // ---- Queue 0 refilled during queue 1's burst ---------------------------
    p0 = pop_cnt[0];
    for (int k = 0; k < 6; k++) src_q[1].push_back(8'hE0 + 8'(k));
    src_q[3].push_back(8'hF0);
    src_q[3].push_back(8'hF1);
    for (int k = 0; k < 4; k++) exp_q.push_back('{qid: QW'(1), data: 8'hE0 + 8'(k)});
    for (int k = 0; k < 10; k++) exp_q.push_back('{qid: QW'(0), data: 8'h50 + 8'(k)});
    exp_q.push_back('{qid: QW'(3), data: 8'hF0});
    exp_q.push_back('{qid: QW'(3), data: 8'hF1});
    exp_q.push_back('{qid: QW'(1), data: 8'hE4});
    exp_q.push_back('{qid: QW'(1), data: 8'hE5});
    acc0 = pop_cnt[1];
    c = 0;
    while (pop_cnt[1] == acc0 && c < 20) begin
      tick(r);
      c++;
    end
    for (int k = 0; k < 10; k++) src_q[0].push_back(8'h50 + 8'(k));
    refresh();
    run_drain("prio0", 1'b0, 100);
    check("prio0_q0_pops", 32'(pop_cnt[0] - p0), 10);
    check("prio0_rr_ptr", 32'(dut.rr_ptr), 2);
    m_ptr = 2;
`endif

    // ---- Randomised rounds with a random consumer --------------------------
    for (int round = 0; round < 8; round++) begin
      for (int q = 0; q < NQ; q++) begin
        int n;
        n = $urandom_range(0, 7);
        for (int k = 0; k < n; k++) src_q[q].push_back(8'($urandom));
      end
      plan();
      run_drain("random", 1'b1, 400);
      check("random_rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
